mode2_word_assembler: RTL and testbench

MODE2_WORD_ASSEMBLER -- requirements
Module: mode2_word_assembler

---
 rtl/mode2_word_assembler_if.sv | 24 ++
 rtl/mode2_word_assembler.sv | 138 +++++++++++++
 tb/tb_mode2_word_assembler.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mode2_word_assembler_if.sv
// rtl/mode2_word_assembler_if.sv - byte-in / word-out handshake bundle for the mode-2 word assembler
interface mode2_word_assembler_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        word_ack;
    logic [23:0] input_word;
    logic        word_valid;

    modport master (
        output rx_data,
        output rx_valid,
        output word_ack,
        input  input_word,
        input  word_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  word_ack,
        output input_word,
        output word_valid
    );
endinterface

// File: rtl/mode2_word_assembler.sv
// rtl/mode2_word_assembler.sv - frames three received bytes (A, opcode, B) into a 24-bit ALU word
// Optional inter-byte timeout enabled by defining MODE2_BYTE_TIMEOUT_EN.
module mode2_word_assembler #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mode2_word_assembler_if.slave   bus,
    input  logic                    clr_err,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        GOT_A,
        GOT_OP,
        FULL
    } state_t;

    state_t      state;
    logic [23:0] word_q;
    logic        word_valid_q;
    logic        overrun_set;
    logic        timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_invalid_timeout_cycles
    end

    assign overrun_set = (state == FULL) && bus.rx_valid && !bus.word_ack;

`ifdef MODE2_BYTE_TIMEOUT_EN
    localparam int              CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] idle_cnt;
    logic          partial;
    logic          timeout_err_q;

    assign partial     = (state == GOT_A) || (state == GOT_OP);
    // The edge that would make the count reach TIMEOUT_CYCLES is the one that fires.
    assign timeout_hit = partial && !bus.rx_valid && (idle_cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (partial && !bus.rx_valid && !timeout_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
        end else if (clr_err) begin
            timeout_err_q <= 1'b0;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            word_q       <= 24'h000000;
            word_valid_q <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        word_q[23:16] <= bus.rx_data;
                        state         <= GOT_A;
                        busy          <= 1'b1;
                    end
                end
                GOT_A: begin
                    if (bus.rx_valid) begin
                        word_q[15:8] <= bus.rx_data;
                        state        <= GOT_OP;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GOT_OP: begin
                    if (bus.rx_valid) begin
                        word_q[7:0]  <= bus.rx_data;
                        state        <= FULL;
                        busy         <= 1'b0;
                        word_valid_q <= 1'b1;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                FULL: begin
                    if (bus.word_ack) begin
                        word_valid_q <= 1'b0;
                        // A byte arriving with the ack starts the next frame instead of overrunning.
                        if (bus.rx_valid) begin
                            word_q[23:16] <= bus.rx_data;
                            state         <= GOT_A;
                            busy          <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    word_valid_q <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase

            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign bus.input_word = word_q;
    assign bus.word_valid = word_valid_q;

endmodule

// File: tb/tb_mode2_word_assembler.sv
// tb/tb_mode2_word_assembler.sv - directed self-checking bench for mode2_word_assembler
module tb_mode2_word_assembler;

    logic clk;
    logic rst_n;
    logic clr_err;
    logic busy;
    logic overrun;
    logic timeout_err;

    int vectors;
    int miscompares;

    mode2_word_assembler_if bus ();

    mode2_word_assembler #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .clr_err     (clr_err),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle strobe; returns 1 time unit after the capturing edge.
    task automatic send_byte(input logic [7:0] d);
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_word();
        bus.word_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.word_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (bus.input_word !== 24'h000000) begin
            miscompares++;
            $display("FAIL reset_word: got %h expected 000000", bus.input_word);
        end
        vectors++;
        if ({bus.word_valid, busy, overrun, timeout_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000", {bus.word_valid, busy, overrun, timeout_err});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        send_byte(8'h12);
        vectors++;
        if ({busy, bus.word_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_after_a busy/valid: got %b expected 10", {busy, bus.word_valid});
        end
        idle(2);
        send_byte(8'h55);
        idle(3);
        send_byte(8'h34);
        vectors++;
        if (bus.word_valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_latency valid/busy: got %b%b expected 10", bus.word_valid, busy);
        end
        vectors++;
        if (bus.input_word !== 24'h125534) begin
            miscompares++;
            $display("FAIL basic_word: got %h expected 125534", bus.input_word);
        end
        for (int i = 0; i < 10; i++) begin
            idle(1);
            vectors++;
            if (bus.word_valid !== 1'b1 || bus.input_word !== 24'h125534) begin
                miscompares++;
                $display("FAIL basic_hold[%0d]: got %b/%h expected 1/125534", i, bus.word_valid, bus.input_word);
            end
        end
        ack_word();
        vectors++;
        if (bus.word_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ack valid/busy: got %b%b expected 00", bus.word_valid, busy);
        end
    endtask

    task automatic test_overrun();
        send_byte(8'h0A);
        send_byte(8'h0E);
        send_byte(8'h03);
        send_byte(8'hFF);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        vectors++;
        if (bus.input_word !== 24'h0A0E03 || bus.word_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_word: got %h/%b expected 0A0E03/1", bus.input_word, bus.word_valid);
        end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
        clr_err = 1'b1;
        send_byte(8'hEE);
        clr_err = 1'b0;
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set_beats_clear: got %b expected 1", overrun);
        end
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        ack_word();
    endtask

    task automatic test_ack_with_byte();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        bus.word_ack = 1'b1;
        send_byte(8'h07);
        bus.word_ack = 1'b0;
        vectors++;
        if ({busy, bus.word_valid, overrun} !== 3'b100) begin
            miscompares++;
            $display("FAIL ackbyte_flags busy/valid/overrun: got %b expected 100", {busy, bus.word_valid, overrun});
        end
        vectors++;
        if (bus.input_word !== 24'h072233) begin
            miscompares++;
            $display("FAIL ackbyte_word: got %h expected 072233", bus.input_word);
        end
        send_byte(8'h08);
        send_byte(8'h09);
        vectors++;
        if (bus.input_word !== 24'h070809 || bus.word_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ackbyte_next_frame: got %h/%b expected 070809/1", bus.input_word, bus.word_valid);
        end
        ack_word();
    endtask

    task automatic test_ack_outside_full();
        ack_word();
        send_byte(8'h40);
        ack_word();
        vectors++;
        if ({busy, bus.word_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL stray_ack busy/valid: got %b expected 10", {busy, bus.word_valid});
        end
        send_byte(8'h41);
        send_byte(8'h42);
        vectors++;
        if (bus.input_word !== 24'h404142 || bus.word_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stray_ack_word: got %h/%b expected 404142/1", bus.input_word, bus.word_valid);
        end
        ack_word();
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h5A);
        send_byte(8'h6B);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.input_word, bus.word_valid, busy, overrun, timeout_err} !== 28'h0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h/%b%b%b%b expected all zero",
                     bus.input_word, bus.word_valid, busy, overrun, timeout_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'hAA);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_first_edge busy: got %b expected 1", busy);
        end
        send_byte(8'h41);
        send_byte(8'h55);
        vectors++;
        if (bus.input_word !== 24'hAA4155 || bus.word_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_word: got %h/%b expected AA4155/1", bus.input_word, bus.word_valid);
        end
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            vectors++;
            if (bus.word_valid !== 1'b0 || bus.input_word !== 24'h000000) begin
                miscompares++;
                $display("FAIL fullreset_no_pulse[%0d]: got %b/%h expected 0/000000", i, bus.word_valid, bus.input_word);
            end
        end
    endtask

`ifdef MODE2_BYTE_TIMEOUT_EN
    task automatic test_timeout();
        send_byte(8'h01);
        send_byte(8'h41);
        idle(7);
        vectors++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early busy/err: got %b%b expected 10", busy, timeout_err);
        end
        idle(1);
        vectors++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_fire busy/err: got %b%b expected 01", busy, timeout_err);
        end
        send_byte(8'h05);
        send_byte(8'h4E);
        send_byte(8'h02);
        vectors++;
        if (bus.input_word !== 24'h054E02 || bus.word_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_next_word: got %h/%b expected 054E02/1", bus.input_word, bus.word_valid);
        end
        ack_word();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: got %b expected 0", timeout_err);
        end
        send_byte(8'h01);
        idle(7);
        send_byte(8'h41);
        vectors++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_last_cycle_byte busy/err: got %b%b expected 10", busy, timeout_err);
        end
        idle(7);
        send_byte(8'h02);
        vectors++;
        if (bus.input_word !== 24'h014102 || bus.word_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_last_cycle_word: got %h/%b expected 014102/1", bus.input_word, bus.word_valid);
        end
        ack_word();
    endtask
`else
    task automatic test_no_timeout();
        send_byte(8'h01);
        send_byte(8'h55);
        idle(5000);
        vectors++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL notimeout_wait busy/err: got %b%b expected 10", busy, timeout_err);
        end
        send_byte(8'h02);
        vectors++;
        if (bus.input_word !== 24'h015502 || bus.word_valid !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL notimeout_word: got %h/%b/%b expected 015502/1/0",
                     bus.input_word, bus.word_valid, timeout_err);
        end
        ack_word();
    endtask
`endif

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b1;
        clr_err      = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.word_ack = 1'b0;
        #1;
        test_reset();
        test_basic_frame();
        test_overrun();
        test_ack_with_byte();
        test_ack_outside_full();
        test_reset_mid_frame();
`ifdef MODE2_BYTE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
